// File: rtl/scaler_pkg.sv
// Shared types and DDR command field widths for the scaler frame-buffer arbiter.
package scaler_pkg;
  localparam int ADDR_W = 28;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_BUSY} state_t;
  typedef enum logic {REQ_WR, REQ_RD} req_t;
endpackage

// File: rtl/scaler_frame_ptr.sv
// Per-requester frame pointer: burst advance, frame wrap, deferred address reset, frame_done pulse.
module scaler_frame_ptr
  import scaler_pkg::*;
#(
  parameter int BURST_LEN   = 64,
  parameter int FRAME_WORDS = 2073600
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              addr_reset,
  input  logic              active,
  input  logic              advance,
  output logic [ADDR_W-1:0] ptr,
  output logic              frame_done
);
  localparam logic [ADDR_W:0] STEP  = (ADDR_W+1)'(BURST_LEN);
  localparam logic [ADDR_W:0] FRAME = (ADDR_W+1)'(FRAME_WORDS);

  logic            pending;
  logic            clr;
  logic [ADDR_W:0] nxt;

  assign nxt = {1'b0, ptr} + STEP;
  // A reset arriving on the completing edge counts like a pending one and beats the wrap.
  assign clr = pending | addr_reset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (advance) begin
        pending    <= 1'b0;
        ptr        <= (clr || nxt == FRAME) ? '0 : nxt[ADDR_W-1:0];
        frame_done <= !clr && (nxt == FRAME);
      end else if (addr_reset) begin
        if (active) pending <= 1'b1;
        else        ptr     <= '0;
      end
    end
  end
endmodule

// File: rtl/scaler_ddr_arb.sv
// Two-requester DDR burst arbiter: write drains the CDC FIFO, read refills the display FIFO.
module scaler_ddr_arb
  import scaler_pkg::*;
#(
  parameter int BURST_LEN   = 64,
  parameter int FRAME_WORDS = 2073600,
  parameter int WR_BASE     = 0,
  parameter int WR_URGENT   = 1536,
  parameter int LVL_W       = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_addr_reset,
  input  logic              rd_addr_reset,
  input  logic              rd_enable,
  input  logic [LVL_W-1:0]  wr_level,
  input  logic [LVL_W-1:0]  rd_space,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              burst_done,
  output logic              grant_wr,
  output logic              grant_rd,
  output logic              wr_frame_done,
  output logic              rd_frame_done
);
  localparam logic [LVL_W-1:0] LVL_BURST  = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0] LVL_URGENT = LVL_W'(WR_URGENT);

  state_t            state, state_nxt;
  req_t              sel, last_grant;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, start_ptr;
  logic              we, re, urgent, elig, pick_wr;

  assign we      = wr_level >= LVL_BURST;
  assign re      = rd_enable && (rd_space >= LVL_BURST);
  assign urgent  = wr_level >= LVL_URGENT;
  assign elig    = urgent | we | re;
  assign pick_wr = urgent | (we & (!re | (last_grant == REQ_RD)));
  assign cmd_len = LEN_W'(BURST_LEN);

  // An address reset on the issuing edge clears the pointer too, so issue from zero.
  always_comb begin
    start_ptr = '0;
    if (pick_wr) start_ptr = wr_addr_reset ? '0 : wr_ptr;
    else         start_ptr = rd_addr_reset ? '0 : rd_ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (elig)       state_nxt = ST_CMD;
      ST_CMD:  if (cmd_ready)  state_nxt = ST_BUSY;
      ST_BUSY: if (burst_done) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid  <= 1'b0;
      cmd_wr     <= 1'b0;
      cmd_addr   <= '0;
      grant_wr   <= 1'b0;
      grant_rd   <= 1'b0;
      sel        <= REQ_RD;
      last_grant <= REQ_RD;
    end else begin
      case (state)
        ST_IDLE: if (elig) begin
          cmd_valid <= 1'b1;
          cmd_wr    <= pick_wr;
          sel       <= pick_wr ? REQ_WR : REQ_RD;
          cmd_addr  <= ADDR_W'(WR_BASE) + start_ptr;
        end
        ST_CMD: if (cmd_ready) begin
          cmd_valid  <= 1'b0;
          grant_wr   <= (sel == REQ_WR);
          grant_rd   <= (sel == REQ_RD);
          last_grant <= sel;
        end
        ST_BUSY: if (burst_done) begin
          grant_wr <= 1'b0;
          grant_rd <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  scaler_frame_ptr #(.BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS)) u_wr_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_reset (wr_addr_reset),
    .active     ((state != ST_IDLE) && (sel == REQ_WR)),
    .advance    ((state == ST_BUSY) && burst_done && (sel == REQ_WR)),
    .ptr        (wr_ptr),
    .frame_done (wr_frame_done)
  );

  scaler_frame_ptr #(.BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS)) u_rd_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_reset (rd_addr_reset),
    .active     ((state != ST_IDLE) && (sel == REQ_RD)),
    .advance    ((state == ST_BUSY) && burst_done && (sel == REQ_RD)),
    .ptr        (rd_ptr),
    .frame_done (rd_frame_done)
  );
endmodule

// File: tb/tb_scaler_ddr_arb.sv
// Directed plus randomized bursts for scaler_ddr_arb, checked against a transaction-level model.
module tb_scaler_ddr_arb;
  import scaler_pkg::*;

  localparam int BL = 64, FW = 256, URG = 1536, LVL_W = 11;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              wr_addr_reset = 1'b0, rd_addr_reset = 1'b0, rd_enable = 1'b0;
  logic              cmd_ready = 1'b0, burst_done = 1'b0;
  logic [LVL_W-1:0]  wr_level = '0, rd_space = '0;
  logic              cmd_valid, cmd_wr, grant_wr, grant_rd, wr_frame_done, rd_frame_done;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  int checks = 0, errors = 0;
  // Model: side 0 = write, 1 = read.
  int mptr[2];
  bit mpend[2];
  int mlast;
  int cur_side;

  always #5 clk = ~clk;

  scaler_ddr_arb #(.FRAME_WORDS(FW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_addr_reset(wr_addr_reset), .rd_addr_reset(rd_addr_reset),
    .rd_enable(rd_enable), .wr_level(wr_level), .rd_space(rd_space), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .burst_done(burst_done), .grant_wr(grant_wr), .grant_rd(grant_rd),
    .wr_frame_done(wr_frame_done), .rd_frame_done(rd_frame_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mptr[0] = 0; mptr[1] = 0; mpend[0] = 0; mpend[1] = 0; mlast = 1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, cmd_valid, 0);
    chk({tag, "_wr"}, cmd_wr, 0);
    chk({tag, "_addr"}, cmd_addr, 0);
    chk({tag, "_grants"}, {grant_wr, grant_rd}, 0);
    chk({tag, "_done"}, {wr_frame_done, rd_frame_done}, 0);
    chk({tag, "_len"}, cmd_len, BL);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_level = '0; rd_space = '0; rd_enable = 0; cmd_ready = 0; burst_done = 0;
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Called at a negedge with the DUT idle; leaves it granted and busy.
  task automatic start_burst(input int wl, input int rs, input int ren, input int stall,
                             input bit rst_busy, input int rst_side);
    int exp_side, n;
    bit we, re, urg;
    logic [ADDR_W-1:0] a0;
    wr_level = LVL_W'(wl); rd_space = LVL_W'(rs); rd_enable = (ren != 0); cmd_ready = 0;
    urg = wl >= URG; we = wl >= BL; re = (ren != 0) && rs >= BL;
    exp_side = (urg || (we && (!re || mlast == 1))) ? 0 : 1;
    n = 0;
    while (n == 0 || (!cmd_valid && n < 8)) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_latency", n, 1);
    chk("cmd_wr", cmd_wr, exp_side == 0);
    chk("cmd_addr", cmd_addr, mptr[exp_side]);
    chk("cmd_len", cmd_len, BL);
    a0 = cmd_addr;
    for (int i = 0; i < stall; i++) begin
      burst_done = (i == 0);
      @(negedge clk);
      chk("stall_valid", cmd_valid, 1);
      chk("stall_addr", cmd_addr, a0);
      chk("stall_nogrant", {grant_wr, grant_rd}, 0);
    end
    burst_done = 0;
    cmd_ready = 1;
    @(negedge clk);
    cmd_ready = 0;
    chk("valid_drop", cmd_valid, 0);
    chk("grant_wr", grant_wr, exp_side == 0);
    chk("grant_rd", grant_rd, exp_side == 1);
    mlast = exp_side;
    cur_side = exp_side;
    if (rst_busy) begin
      if (rst_side == 0) wr_addr_reset = 1; else rd_addr_reset = 1;
      @(negedge clk);
      wr_addr_reset = 0; rd_addr_reset = 0;
      if (rst_side == cur_side) mpend[rst_side] = 1;
      else mptr[rst_side] = 0;
    end
  endtask

  task automatic finish_burst(input int wait_cyc);
    int s, nxt;
    bit exp_done;
    for (int i = 0; i < wait_cyc; i++) @(negedge clk);
    chk("grant_held", cur_side == 0 ? grant_wr : grant_rd, 1);
    burst_done = 1; wr_level = '0; rd_space = '0; rd_enable = 0;
    s = cur_side;
    if (mpend[s]) begin
      mptr[s] = 0; exp_done = 0;
    end else begin
      nxt = mptr[s] + BL;
      exp_done = (nxt == FW);
      mptr[s] = exp_done ? 0 : nxt;
    end
    mpend[s] = 0;
    @(negedge clk);
    burst_done = 0;
    chk("wr_frame_done", wr_frame_done, exp_done && s == 0);
    chk("rd_frame_done", rd_frame_done, exp_done && s == 1);
    chk("grant_drop", {grant_wr, grant_rd}, 0);
    @(negedge clk);
    chk("frame_done_pulse", {wr_frame_done, rd_frame_done}, 0);
    chk("idle_valid", cmd_valid, 0);
  endtask

  task automatic burst(input int wl, input int rs, input int ren, input int stall,
                       input bit rst_busy, input int rst_side, input int wait_cyc);
    start_burst(wl, rs, ren, stall, rst_busy, rst_side);
    finish_burst(wait_cyc);
  endtask

  initial begin
    int wl, rs, ren;
    model_reset();
    #1 chk_all_zero("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset while a write burst is in flight.
    start_burst(64, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1 chk_all_zero("rst_busy");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Round robin: W0, R0, W64, R64.
    for (int i = 0; i < 4; i++) burst(100, 100, 1, 0, 0, 0, 1);

    // Single writer through a frame wrap: 0,64,128,192(done),0.
    do_reset();
    for (int i = 0; i < 5; i++) burst(64, 0, 0, 0, 0, 0, i % 3);

    // Urgent write beats an eligible reader every time.
    for (int i = 0; i < 4; i++) burst(1600, 2000, 1, 0, 0, 0, 0);

    // Deferred write address reset during BUSY with a long command stall.
    burst(64, 0, 0, 0, 0, 0, 0);
    burst(64, 0, 0, 5, 1, 0, 2);
    burst(64, 0, 0, 0, 0, 0, 0);

    // Read address reset while idle, with cmd_ready held high outside CMD.
    burst(0, 100, 1, 0, 0, 0, 0);
    cmd_ready = 1;
    rd_addr_reset = 1;
    @(negedge clk);
    rd_addr_reset = 0;
    mptr[1] = 0;
    @(negedge clk);
    chk("idle_ready_valid", cmd_valid, 0);
    chk("idle_ready_grants", {grant_wr, grant_rd}, 0);
    cmd_ready = 0;
    burst(0, 100, 1, 0, 0, 0, 0);

    // Randomized traffic, resets on either side while busy.
    for (int i = 0; i < 40; i++) begin
      wl  = int'($urandom_range(0, 2047));
      rs  = int'($urandom_range(0, 2047));
      ren = int'($urandom % 2);
      if (!(wl >= BL || (ren != 0 && rs >= BL))) wl = BL + int'($urandom_range(0, 100));
      burst(wl, rs, ren, int'($urandom_range(0, 3)), ($urandom % 4) == 0,
            int'($urandom % 2), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
